// File: rtl/byte_lane_ram.sv
// byte_lane_ram: single-port byte-addressable data RAM with sized
// sign/zero-extended accesses behind a valid/ready request handshake.
module byte_lane_ram #(
  parameter int    W    = 32,
  parameter int    L    = 256,
  parameter string INIT = "zeros.memh",
  parameter int    PIPE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(L*W/8)-1:0] req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [W-1:0]             req_wdata,
  output logic                     rsp_valid,
  output logic [W-1:0]             rsp_rdata,
  output logic                     rsp_err
);
  localparam int NB = W / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(L * NB);
  localparam int RW = AW - OB;
  localparam int SW = (W >= 32) ? 31 : W - 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_n;
  logic   wcnt;
  logic   wcnt_n;
  logic   accept;
  logic   fire;
  logic   stage_en;

  logic [W-1:0]  mem [L];
  logic [W-1:0]  rd_row;
  logic [RW-1:0] row;
  logic [OB-1:0] off;
  logic [3:0]    nbytes;
  logic [2:0]    lo;
  logic          legal;
  logic [15:0]   lane_run;
  logic [NB-1:0] be;
  logic [W-1:0]  wsh;

  assign row      = req_addr[AW-1:OB];
  assign off      = req_addr[OB-1:0];
  assign nbytes   = 4'd1 << req_size;
  assign lo       = 3'(req_addr);
  assign legal    = (int'(nbytes) <= NB)
                 && ((lo & 3'(nbytes - 4'd1)) == 3'd0);
  assign lane_run = (16'd1 << nbytes) - 16'd1;
  assign be       = NB'(lane_run << off);
  assign wsh      = req_wdata << {off, 3'b000};

  // Array is never reset; illegal stores leave it untouched.
  always_ff @(posedge clk) begin
    if (accept && req_we && legal) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[row][i*8 +: 8] <= wsh[i*8 +: 8];
      end
    end
    if (accept && !req_we) rd_row <= mem[row];
  end

  logic [OB-1:0] off_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          ld_q;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      off_q  <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
      ld_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      off_q  <= off;
      size_q <= req_size;
      uns_q  <= req_unsigned;
      ld_q   <= !req_we;
      err_q  <= !legal;
    end
  end

  logic [W-1:0] sh;
  logic [W-1:0] fmt;
  logic [W-1:0] rsp_d;
  logic         sgn;

  always_comb begin
    sh  = rd_row >> {off_q, 3'b000};
    sgn = 1'b0;
    unique case (size_q)
      2'd0:    sgn = sh[7];
      2'd1:    sgn = sh[15];
      2'd2:    sgn = sh[SW];
      default: sgn = sh[W-1];
    endcase
    sgn = sgn & !uns_q;
    fmt = sh;
    for (int i = 0; i < NB; i++) begin
      if (i >= (1 << size_q)) fmt[i*8 +: 8] = {8{sgn}};
    end
    rsp_d = (err_q || !ld_q) ? '0 : fmt;
  end

  logic [W-1:0] stage_data;
  logic         stage_err;
  logic [W-1:0] src_data;
  logic         src_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data <= '0;
      stage_err  <= 1'b0;
    end else if (stage_en) begin
      stage_data <= rsp_d;
      stage_err  <= err_q;
    end
  end

  assign src_data = (PIPE != 0) ? stage_data : rsp_d;
  assign src_err  = (PIPE != 0) ? stage_err : err_q;

  // WAIT covers the array read cycle plus the optional stage.
  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    req_ready = 1'b0;
    stage_en  = 1'b0;
    fire      = 1'b0;
    unique case (1'b1)
      state == IDLE: req_ready = !rst;
      state == WAIT: begin
        if (PIPE != 0 && !wcnt) begin
          wcnt_n   = 1'b1;
          stage_en = 1'b1;
        end else begin
          fire    = 1'b1;
          state_n = RESP;
        end
      end
      state == RESP: begin
        req_ready = !rst;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    accept = req_valid && req_ready;
    if (accept) begin
      state_n = WAIT;
      wcnt_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      rsp_valid <= fire;
      if (fire) begin
        rsp_rdata <= src_data;
        rsp_err   <= src_err;
      end
    end
  end

endmodule

// File: tb/tb_byte_lane_ram.sv
// tb_byte_lane_ram: scoreboarded directed and random traffic against
// byte_lane_ram in three width/pipeline configurations.
module tb_byte_lane_ram;
  typedef struct {
    logic [63:0] data;
    bit          err;
    int          edge_n;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   done [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int CW = (g == 2) ? 64 : 32;
    localparam int CP = (g == 0) ? 0 : 1;
    localparam int CL = 32;
    localparam int NB = CW / 8;
    localparam int AW = $clog2(CL * NB);

    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [CW-1:0] req_wdata;
    logic          rsp_valid;
    logic [CW-1:0] rsp_rdata;
    logic          rsp_err;

    logic [7:0] mb [CL*NB];
    exp_t       sbq [$];

    byte_lane_ram #(
      .W(CW), .L(CL), .INIT(""), .PIPE(CP)
    ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
    );

    task automatic fail_if(input bit bad, input string name,
                           input logic [63:0] act,
                           input logic [63:0] req);
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL cfg%0d %s: got %h want %h", g, name, act, req);
      end
    endtask

    // Reference: byte array, little-endian assembly, then extension.
    task automatic model(input bit we, input int addr, input int sz,
                         input bit uns, input logic [63:0] wd,
                         output exp_t e);
      int nb;
      logic [63:0] v;
      nb = 1 << sz;
      e.data = '0;
      e.err = 1'b0;
      e.edge_n = 0;
      if (nb * 8 > CW || addr % nb != 0) begin
        e.err = 1'b1;
      end else if (we) begin
        for (int i = 0; i < nb; i++) mb[addr + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[addr + i];
        if (!uns && v[8*nb-1]) begin
          for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        e.data = v;
      end
    endtask

    task automatic issue(input bit we, input int addr, input int sz,
                         input bit uns, input logic [63:0] wd,
                         input bit keep, input bit b2b);
      exp_t e;
      int waits;
      waits = 0;
      req_valid = 1'b1;
      req_we = we;
      req_addr = AW'(addr);
      req_size = 2'(sz);
      req_unsigned = uns;
      req_wdata = wd[CW-1:0];
      #1;
      while (!req_ready && waits < 10) begin
        @(negedge clk);
        #1;
        waits++;
      end
      if (!req_ready) begin
        fail_if(1'b1, "ready_timeout", 64'(waits), 64'(1 + CP));
      end else begin
        if (b2b) fail_if(waits != 1 + CP, "b2b_ready_gap",
                         64'(waits), 64'(1 + CP));
        model(we, addr, sz, uns, wd, e);
        e.edge_n = cyc + 1;
        if (keep) sbq.push_back(e);
      end
      @(negedge clk);
    endtask

    task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag, input bit rdy);
      fail_if(rsp_valid !== 1'b0, {tag, "_valid"}, 64'(rsp_valid), 0);
      fail_if(rsp_rdata !== '0, {tag, "_rdata"}, 64'(rsp_rdata), 0);
      fail_if(rsp_err !== 1'b0, {tag, "_err"}, 64'(rsp_err), 0);
      fail_if(req_ready !== rdy, {tag, "_ready"}, 64'(req_ready),
              64'(rdy));
    endtask

    always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          fail_if(1'b1, "unexpected_rsp", 64'(rsp_rdata), 0);
        end else begin : pop
          exp_t e;
          e = sbq.pop_front();
          fail_if(rsp_rdata !== e.data[CW-1:0], "rsp_rdata",
                  64'(rsp_rdata), 64'(e.data[CW-1:0]));
          fail_if(rsp_err !== e.err, "rsp_err", 64'(rsp_err),
                  64'(e.err));
          fail_if(cyc != e.edge_n + 1 + CP, "latency",
                  64'(cyc - e.edge_n), 64'(1 + CP));
        end
      end
    end

    initial begin : drive
      int a;
      int sz;
      bit we;
      bit chain;
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_size = '0;
      req_unsigned = 1'b0;
      req_wdata = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_cleared("reset", 1'b0);
      rst = 1'b0;
      for (int r = 0; r < CL; r++) begin
        issue(1'b1, r * NB, (CW == 64) ? 3 : 2, 1'b0,
              {$urandom, $urandom}, 1'b1, r != 0);
      end
      idle(1);
      issue(1'b1, 'h10, 2, 1'b0, 64'hDEADBEEF, 1'b1, 1'b0); idle(1);
      issue(1'b0, 'h10, 2, 1'b0, 64'h0, 1'b1, 1'b0); idle(1);
      for (int i = 0; i < 4; i++) begin
        issue(1'b1, 'h20 + i, 0, 1'b0, 64'(8'h11 * (i + 1)), 1'b1, 1'b0);
        idle(1);
      end
      issue(1'b0, 'h20, 2, 1'b0, 64'h0, 1'b1, 1'b0); idle(1);
      issue(1'b1, 'h22, 1, 1'b0, 64'hAABB, 1'b1, 1'b0); idle(1);
      issue(1'b0, 'h20, 2, 1'b0, 64'h0, 1'b1, 1'b0); idle(1);
      issue(1'b1, 'h30, 2, 1'b0, 64'h8080, 1'b1, 1'b0); idle(1);
      issue(1'b0, 'h30, 0, 1'b0, 64'h0, 1'b1, 1'b0);
      issue(1'b0, 'h30, 0, 1'b1, 64'h0, 1'b1, 1'b1);
      issue(1'b0, 'h30, 1, 1'b0, 64'h0, 1'b1, 1'b1);
      idle(1);
      issue(1'b1, 'h41, 1, 1'b0, 64'hFFFF, 1'b1, 1'b0); idle(1);
      issue(1'b1, 'h42, 2, 1'b0, 64'h12345678, 1'b1, 1'b0); idle(1);
      issue(1'b0, 'h40, 2, 1'b0, 64'h0, 1'b1, 1'b0); idle(1);
      issue(1'b0, 'h40, 3, 1'b0, 64'h0, 1'b1, 1'b0); idle(1);
      issue(1'b1, 'h48, 3, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0);
      idle(4);
      issue(1'b1, 'h50, 2, 1'b0, 64'hCAFEF00D, 1'b0, 1'b0);
      rst = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_cleared("store_rst", 1'b1);
      idle(3);
      issue(1'b0, 'h50, 2, 1'b0, 64'h0, 1'b1, 1'b0);
      idle(4);
      issue(1'b0, 'h50, 2, 1'b0, 64'h0, 1'b0, 1'b0);
      rst = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_cleared("load_rst", 1'b1);
      idle(3);
      rst = 1'b1;
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = AW'('h50);
      req_size = 2'd2;
      req_wdata = '1;
      #1;
      fail_if(req_ready !== 1'b0, "ready_in_rst", 64'(req_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      issue(1'b0, 'h50, 2, 1'b0, 64'h0, 1'b1, 1'b0);
      idle(1);
      chain = 1'b0;
      repeat (150) begin
        we = 1'($urandom_range(0, 1));
        sz = int'($urandom_range(0, 3));
        a = int'($urandom_range(0, CL * NB - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
        issue(we, a, sz, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, 1'b1, chain);
        chain = ($urandom_range(0, 1) == 1);
        if (!chain) idle(int'($urandom_range(1, 2)));
      end
      idle(6);
      fail_if(sbq.size() != 0, "sb_drain", 64'(sbq.size()), 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 50000; i++) begin
      if (done[0] && done[1] && done[2]) break;
      @(posedge clk);
    end
    compared++;
    if (!(done[0] && done[1] && done[2])) begin
      mismatched++;
      $display("FAIL run_timeout: done %b%b%b want 111",
               done[2], done[1], done[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
